// File: rtl/pkt_gate.sv
// Packet gate: takes one forward/drop decision per buffered packet from the header filter,
// then streams the packet out on AXI4-Stream or drains it, and releases the filter afterwards.
module pkt_gate #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_areset,
    input  logic                                 s_send,
    input  logic                                 s_send_rd,
    output logic                                 hdr_clear,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]       fifo_tdata,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     fifo_tkeep,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      fifo_tuser,
    input  logic                                 fifo_tlast,
    input  logic                                 fifo_empty,
    output logic                                 fifo_rd_en,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [CNT_WIDTH-1:0]                 pkt_fwd_count,
    output logic [CNT_WIDTH-1:0]                 pkt_drop_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECIDE  = 3'd1,
        ST_FORWARD = 3'd2,
        ST_DROP    = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    state_t                 state_r;
    logic                   hdr_clear_r;
    logic [CNT_WIDTH-1:0]   fwd_cnt_r;
    logic [CNT_WIDTH-1:0]   drop_cnt_r;

    logic                   fwd_active_s;
    logic                   drop_active_s;
    logic                   tvalid_s;
    logic                   pop_s;
    logic                   last_pop_s;

    // Datapath strobes decoded from the state; held low while reset is asserted so a
    // mid-packet reset never pops or presents a word during the reset cycle itself.
    always_comb begin
        fwd_active_s  = 1'b0;
        drop_active_s = 1'b0;
        pop_s         = 1'b0;
        if (axi_areset) begin
            fwd_active_s  = 1'b0;
            drop_active_s = 1'b0;
        end else begin
            fwd_active_s  = (state_r == ST_FORWARD);
            drop_active_s = (state_r == ST_DROP);
        end
        tvalid_s = fwd_active_s & ~fifo_empty;
        if (fwd_active_s) begin
            pop_s = tvalid_s & m_axis_tready;
        end else if (drop_active_s) begin
            pop_s = ~fifo_empty;
        end else begin
            pop_s = 1'b0;
        end
        last_pop_s = pop_s & fifo_tlast;
    end

    assign m_axis_tdata   = fifo_tdata;
    assign m_axis_tkeep   = fifo_tkeep;
    assign m_axis_tuser   = fifo_tuser;
    assign m_axis_tlast   = fifo_tlast;
    assign m_axis_tvalid  = tvalid_s;
    assign fifo_rd_en     = pop_s;
    assign hdr_clear      = hdr_clear_r & ~axi_areset;
    assign pkt_fwd_count  = fwd_cnt_r;
    assign pkt_drop_count = drop_cnt_r;

    // Packet sequencing FSM with the registered release pulse and packet counters.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_r     <= ST_IDLE;
            hdr_clear_r <= 1'b0;
            fwd_cnt_r   <= '0;
            drop_cnt_r  <= '0;
        end else begin
            hdr_clear_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (s_send_rd) begin
                        state_r <= ST_DECIDE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DECIDE: begin
                    if (s_send) begin
                        state_r <= ST_FORWARD;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                ST_FORWARD: begin
                    if (last_pop_s) begin
                        state_r     <= ST_CLEAR;
                        hdr_clear_r <= 1'b1;
                        fwd_cnt_r   <= fwd_cnt_r + CNT_ONE;
                    end else begin
                        state_r <= ST_FORWARD;
                    end
                end
                ST_DROP: begin
                    if (last_pop_s) begin
                        state_r     <= ST_CLEAR;
                        hdr_clear_r <= 1'b1;
                        drop_cnt_r  <= drop_cnt_r + CNT_ONE;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                ST_CLEAR: begin
                    state_r <= ST_HOLD;
                end
                // The filter's pending flag is still the old one here, so it is not examined.
                ST_HOLD: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_gate.sv
// Self-checking bench for pkt_gate: per-packet expected timelines and a word scoreboard
// driven by randomized decisions, lengths, back-pressure and FIFO underrun.
module tb_pkt_gate;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int UW = 16;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } word_t;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic          s_send;
    logic          s_send_rd;
    logic          hdr_clear;
    logic [DW-1:0] fifo_tdata;
    logic [KW-1:0] fifo_tkeep;
    logic [UW-1:0] fifo_tuser;
    logic          fifo_tlast;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [CW-1:0] pkt_fwd_count;
    logic [CW-1:0] pkt_drop_count;

    word_t         fifo_q[$];
    logic          hold_empty;
    logic [CW-1:0] exp_fwd;
    logic [CW-1:0] exp_drop;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 axi_aclk = ~axi_aclk;

    pkt_gate #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW),
        .CNT_WIDTH           (CW)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_areset    (axi_areset),
        .s_send        (s_send),
        .s_send_rd     (s_send_rd),
        .hdr_clear     (hdr_clear),
        .fifo_tdata    (fifo_tdata),
        .fifo_tkeep    (fifo_tkeep),
        .fifo_tuser    (fifo_tuser),
        .fifo_tlast    (fifo_tlast),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pkt_fwd_count (pkt_fwd_count),
        .pkt_drop_count(pkt_drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the FWFT head of the bench FIFO; called only at the falling edge.
    task automatic present();
        fifo_empty = hold_empty || (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            fifo_tdata = fifo_q[0].d;
            fifo_tkeep = fifo_q[0].k;
            fifo_tuser = fifo_q[0].u;
            fifo_tlast = fifo_q[0].l;
        end else begin
            fifo_tdata = '0;
            fifo_tkeep = '0;
            fifo_tuser = '0;
            fifo_tlast = 1'b0;
        end
    endtask

    task automatic next_cycle();
        if (fifo_rd_en && !fifo_empty && fifo_q.size() != 0) void'(fifo_q.pop_front());
        @(posedge axi_aclk);
        @(negedge axi_aclk);
    endtask

    task automatic quiet(input string tag, input logic exp_clr);
        chk({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, ".rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, ".hdr_clear"}, 64'(hdr_clear), 64'(exp_clr));
        chk({tag, ".fwd_cnt"}, 64'(pkt_fwd_count), 64'(exp_fwd));
        chk({tag, ".drop_cnt"}, 64'(pkt_drop_count), 64'(exp_drop));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            s_send_rd = 1'b0;
            s_send = 1'($urandom);
            m_axis_tready = 1'($urandom);
            hold_empty = 1'b0;
            present();
            #1;
            quiet("idle", 1'b0);
            next_cycle();
        end
    endtask

    // One packet: IDLE, DECIDE, data phase, CLEAR, HOLD. rmode: 0 ready, 1 random, 2 pattern 1,0,0.
    task automatic run_packet(input bit fwd, input int n, input bit b2b, input int rmode, input int empty_pct);
        word_t pkt[$];
        int    k;
        int    cyc;
        bit    avail;
        bit    exp_valid;
        bit    exp_rd;
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.d = {$urandom, $urandom};
            w.k = (i == n - 1) ? KW'($urandom_range(1, 255)) : {KW{1'b1}};
            w.u = UW'($urandom);
            w.l = (i == n - 1);
            pkt.push_back(w);
            fifo_q.push_back(w);
        end
        hold_empty = 1'b0;
        s_send_rd = 1'b1;
        s_send = !fwd;
        m_axis_tready = 1'($urandom);
        present();
        #1;
        quiet("pkt_idle", 1'b0);
        next_cycle();
        s_send = fwd;
        present();
        #1;
        quiet("pkt_decide", 1'b0);
        next_cycle();
        k = 0;
        cyc = 0;
        while (k < n && cyc < 400) begin
            s_send = 1'($urandom);
            hold_empty = ($urandom_range(0, 99) < empty_pct);
            case (rmode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = 1'($urandom);
                default: m_axis_tready = (cyc % 3 == 0);
            endcase
            present();
            #1;
            avail = !fifo_empty;
            exp_valid = fwd && avail;
            exp_rd = avail && (fwd ? m_axis_tready : 1'b1);
            chk("data.tvalid", 64'(m_axis_tvalid), 64'(exp_valid));
            chk("data.rd_en", 64'(fifo_rd_en), 64'(exp_rd));
            chk("data.hdr_clear", 64'(hdr_clear), 64'd0);
            if (exp_valid) begin
                chk("data.tdata", 64'(m_axis_tdata), 64'(pkt[k].d));
                chk("data.tkeep", 64'(m_axis_tkeep), 64'(pkt[k].k));
                chk("data.tuser", 64'(m_axis_tuser), 64'(pkt[k].u));
                chk("data.tlast", 64'(m_axis_tlast), 64'(pkt[k].l));
            end
            if (exp_rd) k++;
            next_cycle();
            cyc++;
        end
        chk("pkt_complete", 64'(k), 64'(n));
        if (rmode == 0 && empty_pct == 0) chk("pkt_latency", 64'(cyc), 64'(n));
        if (fwd) exp_fwd = exp_fwd + 4'd1;
        else     exp_drop = exp_drop + 4'd1;
        hold_empty = 1'b0;
        s_send_rd = 1'b1;
        present();
        #1;
        quiet("pkt_clear", 1'b1);
        next_cycle();
        s_send = 1'($urandom);
        present();
        #1;
        quiet("pkt_hold", 1'b0);
        next_cycle();
        s_send_rd = b2b;
    endtask

    initial begin
        axi_areset = 1'b1;
        s_send = 1'b0;
        s_send_rd = 1'b0;
        m_axis_tready = 1'b0;
        hold_empty = 1'b0;
        exp_fwd = '0;
        exp_drop = '0;
        present();
        repeat (3) begin
            @(posedge axi_aclk);
            @(negedge axi_aclk);
        end
        #1;
        quiet("reset", 1'b0);
        axi_areset = 1'b0;
        idle_cycles(2);

        run_packet(1'b1, 3, 1'b0, 0, 0);
        idle_cycles(2);
        run_packet(1'b0, 2, 1'b0, 1, 0);
        idle_cycles(1);
        run_packet(1'b1, 4, 1'b0, 2, 0);
        idle_cycles(1);
        run_packet(1'b1, 3, 1'b1, 0, 0);
        run_packet(1'b0, 2, 1'b0, 0, 0);
        idle_cycles(1);
        run_packet(1'b1, 1, 1'b0, 0, 0);
        run_packet(1'b0, 1, 1'b0, 0, 0);

        for (int p = 0; p < 30; p++) begin
            bit f;
            bit b;
            f = 1'($urandom);
            b = (p < 29) ? 1'($urandom) : 1'b0;
            run_packet(f, $urandom_range(1, 6), b, 1, 20);
            if (!b) idle_cycles($urandom_range(0, 3));
        end

        // Reset after the second word of a five-word forward.
        for (int i = 0; i < 5; i++) begin
            word_t w;
            w.d = {$urandom, $urandom};
            w.k = {KW{1'b1}};
            w.u = UW'($urandom);
            w.l = (i == 4);
            fifo_q.push_back(w);
        end
        s_send_rd = 1'b1;
        s_send = 1'b0;
        m_axis_tready = 1'b1;
        present();
        #1;
        quiet("rst_idle", 1'b0);
        next_cycle();
        s_send = 1'b1;
        present();
        #1;
        quiet("rst_decide", 1'b0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            present();
            #1;
            chk("rst_fwd.tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("rst_fwd.rd_en", 64'(fifo_rd_en), 64'd1);
            next_cycle();
        end
        axi_areset = 1'b1;
        s_send_rd = 1'b0;
        present();
        #1;
        chk("rst_mid.tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_mid.rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_mid.hdr_clear", 64'(hdr_clear), 64'd0);
        next_cycle();
        axi_areset = 1'b0;
        exp_fwd = '0;
        exp_drop = '0;
        for (int i = 0; i < 3; i++) begin
            present();
            #1;
            quiet("rst_after", 1'b0);
            next_cycle();
        end
        chk("rst_fifo_left", 64'(fifo_q.size()), 64'd3);
        fifo_q.delete();

        for (int p = 0; p < 17; p++) begin
            run_packet(1'b0, 1, 1'b0, 1, 0);
            idle_cycles(1);
        end
        chk("wrap.drop_cnt", 64'(pkt_drop_count), 64'd1);
        chk("wrap.fwd_cnt", 64'(pkt_fwd_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
